rs_pipeline_flow_ctrl: RTL

Credit-based flow controller for a relay-station FF pipeline between a head region and a tail region. It carries a valid/ready stream across PIPE_LEVEL register stages, buffers it in a tail FIFO, and returns credits over CREDIT_LEVEL register stages. The head never accepts more words than the tail FIFO can hold, so no backpressure path needs to cross the pipeline combinationally. It is the sequencing companion of the pipeline clock-distribution aux block and runs in the same single clock domain.

---
 rtl/rs_pipeline_flow_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rs_pipeline_flow_ctrl.sv
// rs_pipeline_flow_ctrl
// Credit-based flow controller for a relay-station register pipeline.
// Head words travel through PIPE_LEVEL register stages into a DEPTH-entry
// tail FIFO. Each pop sends a credit back through CREDIT_LEVEL register stages.
// The head only accepts a word while it holds a credit, so the tail never has
// to push back combinationally across the pipeline.
//
// Ports:
//   clk, rst_n    single clock, asynchronous active-low reset
//   in_valid      head word valid
//   in_ready      head accept; it is decoded from registers only
//   in_data       head payload
//   out_valid     tail FIFO non-empty
//   out_ready     tail consumer accept
//   out_data      FIFO head entry (first-word fall-through)
//   credit_cnt    credits available at the head
//   fifo_cnt      tail FIFO occupancy
//   err_overflow  sticky; FIFO written while full without a simultaneous pop
module rs_pipeline_flow_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int PIPE_LEVEL   = 2,
  parameter int CREDIT_LEVEL = 2,
  parameter int DEPTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   credit_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt,
  output logic                         err_overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic                  ready_en;
  logic                  accept;
  logic                  pop;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ok;
  logic                  credit_ret;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign in_ready  = ready_en && (credit_cnt != '0);
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  // Holds the head closed for the whole reset and for the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Forward path: a shift register that never stalls. With zero stages an
  // accept writes the FIFO directly.
  generate
    if (PIPE_LEVEL == 0) begin : g_fwd_bypass
      assign wr_en   = accept;
      assign wr_data = in_data;
    end else begin : g_fwd_pipe
      logic [PIPE_LEVEL-1:0] vld;
      logic [DATA_WIDTH-1:0] dat [PIPE_LEVEL];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= '0;
        end else begin
          vld[0] <= accept;
          for (int i = 1; i < PIPE_LEVEL; i++) vld[i] <= vld[i-1];
        end
      end

      // Payload is qualified by vld, so it is not reset.
      always_ff @(posedge clk) begin
        dat[0] <= in_data;
        for (int i = 1; i < PIPE_LEVEL; i++) dat[i] <= dat[i-1];
      end

      assign wr_en   = vld[PIPE_LEVEL-1];
      assign wr_data = dat[PIPE_LEVEL-1];
    end
  endgenerate

  // Credit return path: one pulse per pop, delayed by CREDIT_LEVEL stages.
  generate
    if (CREDIT_LEVEL == 0) begin : g_cred_bypass
      assign credit_ret = pop;
    end else begin : g_cred_pipe
      logic [CREDIT_LEVEL-1:0] cvld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cvld <= '0;
        end else begin
          cvld[0] <= pop;
          for (int i = 1; i < CREDIT_LEVEL; i++) cvld[i] <= cvld[i-1];
        end
      end

      assign credit_ret = cvld[CREDIT_LEVEL-1];
    end
  endgenerate

  // If an accept and a returning credit happen in the same cycle, they cancel.
  // Accepts are gated by credit_cnt != 0, so only the increment needs a bound.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= FULL_CNT;
    end else begin
      case ({accept, credit_ret})
        2'b10:   credit_cnt <= credit_cnt - CW'(1);
        2'b01:   if (credit_cnt != FULL_CNT) credit_cnt <= credit_cnt + CW'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // When the FIFO is full, a write goes ahead only if a pop frees the slot in
  // the same cycle. In that case wr_ptr equals rd_ptr, and the entry being
  // read out is replaced at the same edge.
  assign wr_ok = wr_en && ((fifo_cnt != FULL_CNT) || pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (wr_en && !wr_ok) err_overflow <= 1'b1;
    end
  end

endmodule
